// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types plus hazard-controller state and bar-mask constants.
// rev 1.0
`default_nettype none
package cpu_types_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_BARS = 4;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2,
    HALTED    = 2'd3
  } hzstate_t;

  localparam int BAR_IFID  = 0;
  localparam int BAR_IDEX  = 1;
  localparam int BAR_EXMEM = 2;
  localparam int BAR_MEMWB = 3;

  localparam logic [NUM_BARS-1:0] BARS_NONE    = 4'b0000;
  localparam logic [NUM_BARS-1:0] BARS_ALL     = 4'b1111;
  localparam logic [NUM_BARS-1:0] BARS_HOLD_IF = ~(4'b0001 << BAR_IFID);
  localparam logic [NUM_BARS-1:0] FLUSH_SQUASH = (4'b0001 << BAR_IFID) |
                                                 (4'b0001 << BAR_IDEX) |
                                                 (4'b0001 << BAR_EXMEM);
  localparam logic [NUM_BARS-1:0] FLUSH_BUBBLE = 4'b0001 << BAR_IDEX;
  localparam logic [NUM_BARS-1:0] FLUSH_FETCH  = 4'b0001 << BAR_IFID;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational decode of memory request, taken branch/jump and load-use match.
// rev 1.0
`default_nettype none
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     dREN_3,
  input  logic     dWEN_3,
  input  regbits_t rs_1,
  input  regbits_t rt_1,
  input  logic     dREN_2,
  input  regbits_t rt_2,
  input  logic     beq_3,
  input  logic     bne_3,
  input  logic     zero_3,
  input  logic     j_3,
  input  logic     JR_3,
  input  logic     jal_3,
  output logic     memreq,
  output logic     taken,
  output logic     lu,
  output logic     match_a,
  output logic     match_b
);

  assign memreq  = dREN_3 | dWEN_3;
  assign taken   = (beq_3 & zero_3) | (bne_3 & ~zero_3) | j_3 | JR_3 | jal_3;
  assign match_a = (rt_2 == rs_1);
  assign match_b = (rt_2 == rt_1);
  // r0 is hardwired zero, so a load into it never creates a dependency
  assign lu      = dREN_2 & (rt_2 != '0) & (match_a | match_b);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect/halt control for the four pipeline bars.
// rev 1.0 -- define HAZ_PERF_CNT_EN to add stall_cycles/squash_count counters.
`default_nettype none
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int BARS       = 4,
  parameter int LU_BUBBLES = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            dREN_3,
  input  logic            dWEN_3,
  input  regbits_t        rs_1,
  input  regbits_t        rt_1,
  input  logic            dREN_2,
  input  regbits_t        rt_2,
  input  logic            beq_3,
  input  logic            bne_3,
  input  logic            zero_3,
  input  logic            j_3,
  input  logic            JR_3,
  input  logic            jal_3,
  input  logic            halt_4,
  output logic            pc_en,
  output logic            pc_redirect,
  output logic [BARS-1:0] bar_en,
  output logic [BARS-1:0] bar_flush,
  output logic            lwForwardA,
  output logic            lwForwardB,
  output logic            halt
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     squash_count
`endif
);

  localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

  logic     memreq, taken, lu, match_a, match_b;
  hzstate_t state, state_nxt;
  logic [1:0] bub_cnt, bub_cnt_nxt;
  logic     fwd_a, fwd_b, fwd_a_nxt, fwd_b_nxt;

  hazard_detect u_detect (
    .dREN_3  (dREN_3),
    .dWEN_3  (dWEN_3),
    .rs_1    (rs_1),
    .rt_1    (rt_1),
    .dREN_2  (dREN_2),
    .rt_2    (rt_2),
    .beq_3   (beq_3),
    .bne_3   (bne_3),
    .zero_3  (zero_3),
    .j_3     (j_3),
    .JR_3    (JR_3),
    .jal_3   (jal_3),
    .memreq  (memreq),
    .taken   (taken),
    .lu      (lu),
    .match_a (match_a),
    .match_b (match_b)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      bub_cnt <= 2'd0;
      fwd_a   <= 1'b0;
      fwd_b   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
      fwd_a   <= fwd_a_nxt;
      fwd_b   <= fwd_b_nxt;
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    bar_en      = BARS_NONE;
    bar_flush   = BARS_NONE;
    lwForwardA  = 1'b0;
    lwForwardB  = 1'b0;
    halt        = 1'b0;
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    fwd_a_nxt   = fwd_a;
    fwd_b_nxt   = fwd_b;

    if (RST) begin
      bar_flush = BARS_ALL;
      state_nxt = RUN;
    end else if (state == HALTED || halt_4) begin
      halt      = 1'b1;
      state_nxt = HALTED;
    end else if (memreq && !dhit) begin
      // full freeze; on the dhit cycle MEM_WAIT falls through and evaluates like RUN
      state_nxt = MEM_WAIT;
    end else if (taken) begin
      pc_en       = 1'b1;
      pc_redirect = 1'b1;
      bar_en      = BARS_ALL;
      bar_flush   = FLUSH_SQUASH;
      state_nxt   = RUN;
    end else if (state == LU_BUBBLE) begin
      if (bub_cnt != 2'd0) begin
        bar_en      = BARS_HOLD_IF;
        bar_flush   = FLUSH_BUBBLE;
        bub_cnt_nxt = bub_cnt - 2'd1;
      end else begin
        pc_en      = ihit;
        bar_en     = BARS_ALL;
        bar_flush  = ihit ? BARS_NONE : FLUSH_FETCH;
        lwForwardA = fwd_a;
        lwForwardB = fwd_b;
        state_nxt  = RUN;
      end
    end else if (lu) begin
      bar_en      = BARS_HOLD_IF;
      bar_flush   = FLUSH_BUBBLE;
      bub_cnt_nxt = LU_LOAD;
      fwd_a_nxt   = match_a;
      fwd_b_nxt   = match_b;
      state_nxt   = LU_BUBBLE;
    end else if (!ihit) begin
      bar_en    = BARS_ALL;
      bar_flush = FLUSH_FETCH;
      state_nxt = RUN;
    end else begin
      pc_en     = 1'b1;
      bar_en    = BARS_ALL;
      state_nxt = RUN;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, squash_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q  <= 32'd0;
      squash_q <= 32'd0;
    end else begin
      if (!pc_en && state != HALTED) stall_q <= stall_q + 32'd1;
      if (pc_redirect)               squash_q <= squash_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign squash_count = squash_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random checks of two controllers (LU_BUBBLES=1 and 2).
// rev 1.0
`default_nettype none
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, dREN_3, dWEN_3, dREN_2;
  logic [4:0] rs_1, rt_1, rt_2;
  logic       beq_3, bne_3, zero_3, j_3, JR_3, jal_3, halt_4;

  logic       pc_en1, pc_redir1, lwfa1, lwfb1, halt1;
  logic [3:0] bar_en1, bar_flush1;
  logic       pc_en2, pc_redir2, lwfa2, lwfb2, halt2;
  logic [3:0] bar_en2, bar_flush2;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall1, squash1, stall2, squash2;
`endif

  int total = 0;
  int bad   = 0;

  // reference-model state per instance: stall cycles still owed, pending forward pulse
  int m_owe  [2];
  bit m_fwd  [2];
  bit m_fa   [2];
  bit m_fb   [2];
  bit m_halt [2];

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.BARS(4), .LU_BUBBLES(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_3(dREN_3), .dWEN_3(dWEN_3),
    .rs_1(rs_1), .rt_1(rt_1), .dREN_2(dREN_2), .rt_2(rt_2), .beq_3(beq_3), .bne_3(bne_3),
    .zero_3(zero_3), .j_3(j_3), .JR_3(JR_3), .jal_3(jal_3), .halt_4(halt_4),
    .pc_en(pc_en1), .pc_redirect(pc_redir1), .bar_en(bar_en1), .bar_flush(bar_flush1),
    .lwForwardA(lwfa1), .lwForwardB(lwfb1), .halt(halt1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall1), .squash_count(squash1)
`endif
  );

  pipeline_hazard_ctrl #(.BARS(4), .LU_BUBBLES(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_3(dREN_3), .dWEN_3(dWEN_3),
    .rs_1(rs_1), .rt_1(rt_1), .dREN_2(dREN_2), .rt_2(rt_2), .beq_3(beq_3), .bne_3(bne_3),
    .zero_3(zero_3), .j_3(j_3), .JR_3(JR_3), .jal_3(jal_3), .halt_4(halt_4),
    .pc_en(pc_en2), .pc_redirect(pc_redir2), .bar_en(bar_en2), .bar_flush(bar_flush2),
    .lwForwardA(lwfa2), .lwForwardB(lwfb2), .halt(halt2)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall2), .squash_count(squash2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {pc_en, pc_redirect, bar_en, bar_flush, lwFwdA, lwFwdB, halt}
  task automatic model(input int k, output logic [12:0] e);
    int   nb = k + 1;
    bit   memreq, taken, lu;
    logic pe, pr, fa, fb, h;
    logic [3:0] en, fl;
    memreq = dREN_3 | dWEN_3;
    taken  = (beq_3 && zero_3) || (bne_3 && !zero_3) || j_3 || JR_3 || jal_3;
    lu     = dREN_2 && (rt_2 != 0) && (rt_2 == rs_1 || rt_2 == rt_1);
    pe = 0; pr = 0; fa = 0; fb = 0; h = 0; en = 4'b0000; fl = 4'b0000;
    if (RST) begin
      fl = 4'b1111; m_owe[k] = 0; m_fwd[k] = 0; m_halt[k] = 0;
    end else if (m_halt[k] || halt_4) begin
      h = 1; m_halt[k] = 1;
    end else if (memreq && !dhit) begin
      m_owe[k] = 0; m_fwd[k] = 0;
    end else if (taken) begin
      pe = 1; pr = 1; en = 4'b1111; fl = 4'b0111; m_owe[k] = 0; m_fwd[k] = 0;
    end else if (m_owe[k] > 0) begin
      en = 4'b1110; fl = 4'b0010; m_owe[k]--;
    end else if (m_fwd[k]) begin
      fa = m_fa[k]; fb = m_fb[k]; en = 4'b1111; pe = ihit; fl = ihit ? 4'b0000 : 4'b0001;
      m_fwd[k] = 0;
    end else if (lu) begin
      en = 4'b1110; fl = 4'b0010; m_owe[k] = nb - 1; m_fwd[k] = 1;
      m_fa[k] = (rt_2 == rs_1); m_fb[k] = (rt_2 == rt_1);
    end else if (!ihit) begin
      en = 4'b1111; fl = 4'b0001;
    end else begin
      pe = 1; en = 4'b1111;
    end
    e = {pe, pr, en, fl, fa, fb, h};
  endtask

  task automatic eval();
    logic [12:0] e1, e2;
    @(negedge CLK);
    model(0, e1);
    model(1, e2);
    chk("dut1_outputs", 32'({pc_en1, pc_redir1, bar_en1, bar_flush1, lwfa1, lwfb1, halt1}), 32'(e1));
    chk("dut2_outputs", 32'({pc_en2, pc_redir2, bar_en2, bar_flush2, lwfa2, lwfb2, halt2}), 32'(e2));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    ihit = 1; dhit = 1; dREN_3 = 0; dWEN_3 = 0; dREN_2 = 0;
    rs_1 = 0; rt_1 = 0; rt_2 = 0;
    beq_3 = 0; bne_3 = 0; zero_3 = 0; j_3 = 0; JR_3 = 0; jal_3 = 0; halt_4 = 0;
  endtask

  initial begin
    RST = 1; quiet();

    // reset
    eval();
    chk("rst_flush", 32'(bar_flush1), 32'h0000_000f);
    chk("rst_en",    32'(bar_en1),    32'h0);
    chk("rst_pc_en", 32'(pc_en1),     32'h0);
    tick(); eval(); tick();
    RST = 0;
    eval();
    chk("post_rst_pc_en",  32'(pc_en1),  32'h1);
    chk("post_rst_bar_en", 32'(bar_en1), 32'hf);
    tick();

    // data-cache miss for 3 cycles
    dREN_3 = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("memwait_bar_en", 32'(bar_en1), 32'h0);
      chk("memwait_pc_en",  32'(pc_en1),  32'h0);
      tick();
    end
    dhit = 1;
    eval();
    chk("memwait_release", 32'(pc_en1), 32'h1);
    tick();
    dREN_3 = 0;
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cycles", stall1, 32'd3);
`endif

    // load-use on rs: one bubble then forward A
    dREN_2 = 1; rt_2 = 5; rs_1 = 5; rt_1 = 3;
    eval();
    chk("lu_pc_en",  32'(pc_en1),     32'h0);
    chk("lu_bar_en", 32'(bar_en1),    32'he);
    chk("lu_flush",  32'(bar_flush1), 32'h2);
    tick();
    dREN_2 = 0;
    eval();
    chk("lu_fwd_a", 32'(lwfa1), 32'h1);
    chk("lu_fwd_b", 32'(lwfb1), 32'h0);
    tick();
    eval();
    chk("lu_fwd_clear", 32'({lwfa1, lwfb1}), 32'h0);
    tick(); eval(); tick();

    // r0 never stalls
    dREN_2 = 1; rt_2 = 0; rs_1 = 0; rt_1 = 4;
    eval();
    chk("lu_r0_pc_en", 32'(pc_en2), 32'h1);
    tick();

    // load-use on rt with two bubbles
    rt_2 = 7; rs_1 = 1; rt_1 = 7;
    eval();
    chk("lu2_stall0", 32'(pc_en2), 32'h0);
    tick();
    dREN_2 = 0;
    eval();
    chk("lu2_stall1", 32'(pc_en2), 32'h0);
    tick();
    eval();
    chk("lu2_fwd_b", 32'(lwfb2), 32'h1);
    tick();

    // taken bne beats a simultaneous load-use
    bne_3 = 1; zero_3 = 0; dREN_2 = 1; rt_2 = 5; rs_1 = 5;
    eval();
    chk("redir_sel",   32'(pc_redir1),  32'h1);
    chk("redir_flush", 32'(bar_flush1), 32'h7);
    tick();
    quiet();
    eval();
    chk("redir_no_bubble", 32'({pc_en1, lwfa1, lwfb1}), 32'h4);
    tick();
`ifdef HAZ_PERF_CNT_EN
    chk("squash_count", squash1, 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ihit   = ($urandom_range(0, 3) != 0);
      dREN_3 = ($urandom_range(0, 4) == 0);
      dWEN_3 = ($urandom_range(0, 6) == 0);
      dhit   = ($urandom_range(0, 1) == 0);
      dREN_2 = ($urandom_range(0, 1) == 0);
      rs_1   = 5'($urandom_range(0, 3));
      rt_1   = 5'($urandom_range(0, 3));
      rt_2   = 5'($urandom_range(0, 3));
      beq_3  = ($urandom_range(0, 7) == 0);
      bne_3  = ($urandom_range(0, 7) == 0);
      zero_3 = $urandom_range(0, 1) != 0;
      j_3    = ($urandom_range(0, 19) == 0);
      JR_3   = ($urandom_range(0, 29) == 0);
      jal_3  = ($urandom_range(0, 29) == 0);
      eval();
      tick();
    end

    // halt arriving during a memory wait is sticky
    quiet();
    dREN_3 = 1; dhit = 0;
    eval(); tick(); eval(); tick();
    halt_4 = 1;
    eval(); tick();
    quiet();
    for (int i = 0; i < 8; i++) begin
      j_3  = $urandom_range(0, 1) != 0;
      ihit = i[0];
      eval();
      tick();
    end
    eval();
    chk("halt_sticky", 32'({halt1, pc_en1, bar_en1}), 32'h20);
    tick();
    RST = 1; quiet();
    eval(); tick();
    RST = 0;
    eval();
    chk("halt_cleared", 32'({halt1, pc_en1}), 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Control-side counterpart to the four pipeline register bars. It reads the bar outputs (IF/ID fields, ID/EX load info, EX/MEM branch/memory info, MEM/WB halt) and drives each bar's enable/flush, the PC enable/redirect and the lwForward flags back into the bars. It handles cache-miss freezes, load-use bubbles, taken-branch squashes and halt.

Parameters:
BARS, 4, number of register bars controlled (fixed 4; one bit per bar in vectors, bit0 = IF/ID)
LU_BUBBLES, 1, bubble cycles inserted per load-use hazard (1..3)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_3, dWEN_3  in  1  EX/MEM bar memory request
rs_1, rt_1  in  5 (regbits_t)  source registers decoded from IF/ID instr
dREN_2  in  1  ID/EX holds a load
rt_2  in  5  ID/EX load destination
beq_3, bne_3, zero_3, j_3, JR_3, jal_3  in  1  EX/MEM branch/jump info
halt_4  in  1  MEM/WB halt_or
pc_en  out  1  PC update enable
pc_redirect  out  1  select branch/jump target in PC mux
bar_en  out  4  per-bar enable
bar_flush  out  4  per-bar flush (load bubble on next edge)
lwForwardA, lwForwardB  out  1  to lwForward*_in_2
halt  out  1  sticky halt to datapath/cache

Behaviour:
- States (hzstate_t): RUN, LU_BUBBLE, MEM_WAIT, HALTED. Reset state RUN, bubble counter 0.
- While RST high: pc_en=0, pc_redirect=0, bar_en=4'b0000, bar_flush=4'b1111, lwForward*=0, halt=0.
- memreq = dREN_3|dWEN_3; taken = (beq_3&zero_3)|(bne_3&~zero_3)|j_3|JR_3|jal_3; lu = dREN_2 & rt_2!=0 & (rt_2==rs_1 | rt_2==rt_1).
- Priority per cycle: halt > memory wait > redirect > load-use > fetch miss.
- HALTED: entered on the edge where halt_4=1 from any state. All outputs 0 except halt=1. Leaves only on RST.
- Memory wait (memreq & ~dhit): bar_en=0, pc_en=0, bar_flush=0. State goes to MEM_WAIT. The state is held while ~dhit. On the dhit cycle the block evaluates as RUN and moves to the next state.
- Redirect (taken and no mem wait): pc_en=1, pc_redirect=1, bar_en=4'b1111, bar_flush=4'b0111 (squash IF/ID, ID/EX, EX/MEM inputs). A pending lu the same cycle is ignored.
- Load-use in RUN: pc_en=0, bar_en=4'b1110 (IF/ID holds), bar_flush=4'b0010 (ID/EX bubble). Record matchA=(rt_2==rs_1) and matchB=(rt_2==rt_1). Counter is loaded with LU_BUBBLES-1 and the state goes to LU_BUBBLE. If LU_BUBBLES=1, LU_BUBBLE lasts one cycle.
- LU_BUBBLE: counter>0 repeats the stall pattern and decrements. At counter==0, normal advance with lwForwardA=matchA and lwForwardB=matchB for exactly this cycle, then RUN.
- Fetch miss (~ihit, no higher event): pc_en=0, bar_en=4'b1111, bar_flush=4'b0001.
- Normal: pc_en=1, bar_en=4'b1111, bar_flush=0, pc_redirect=0.
- MEM_WAIT interrupted by halt_4 goes to HALTED. A redirect arriving during MEM_WAIT is serviced on the dhit cycle.

Optional Feature:
HAZ_PERF_CNT_EN: adds outputs stall_cycles[31:0] and squash_count[31:0]. Both reset to 0 and wrap at 2^32.
- stall_cycles increments each cycle pc_en=0 outside HALTED.
- squash_count increments per redirect cycle.
Without the macro these ports and counters do not exist.

Decomposition:
- cpu_types_pkg: hzstate_t enum, regbits_t (existing), BAR_IFID..BAR_MEMWB index constants.
- One sub-module, hazard_detect: purely combinational. Computes taken, lu, matchA/matchB and memreq.

Test Plan:
- RST high 2 cycles, then low with ihit=1: bar_flush=1111 and bar_en=0 during reset; first cycle after reset shows pc_en=1, bar_en=1111.
- Load-use: dREN_2=1, rt_2=5, rs_1=5, rt_1=3 → one cycle with pc_en=0, bar_en=1110, bar_flush=0010; next cycle lwForwardA=1, lwForwardB=0, then both 0.
- Load-use with LU_BUBBLES=2, rt_2=0 matching rs_1=0 → no stall (r0 excluded). Same with rt_2=7=rt_1 → two stall cycles, then lwForwardB pulse.
- bne_3=1, zero_3=0 while lu also true → pc_redirect=1, bar_flush=0111, no bubble, no lwForward.
- dREN_3=1, dhit=0 for 3 cycles, then 1 → bar_en=0000, pc_en=0 for 3 cycles; advances on the dhit cycle. With HAZ_PERF_CNT_EN, stall_cycles=3.
- halt_4=1 mid MEM_WAIT → halt=1 and all enables 0 until RST. A subsequent taken branch and ihit toggles produce no change.
